// File: rtl/song_sequencer.sv
// Song sequencer: records player notes in EDIT mode and plays them back in
// RUN mode on a difficulty-scaled beat, reporting progress to the mode FSM.
//
// Handshake: there is no valid/ready pair here. note_valid is a one-cycle
// strobe and note_lanes is only meaningful in that cycle; the consumer cannot
// stall the stream.
module song_sequencer #(
   parameter int NUM_NOTES  = 42,
   parameter int BEAT_TICKS = 1200000
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [2:0] mode,
   input  logic [1:0] diff,
   input  logic       wr_en,
   input  logic [3:0] wr_lane,
   output logic [5:0] edit_count,
   output logic [3:0] note_lanes,
   output logic       note_valid,
   output logic [5:0] note_count,
   output logic       song_done
);

   typedef enum logic [2:0] {
      M_IDLE   = 3'd1,
      M_EDIT   = 3'd2,
      M_DIFF   = 3'd3,
      M_RUN    = 3'd4,
      M_PAUSE  = 3'd5,
      M_FINISH = 3'd6
   } mode_t;

   localparam logic [5:0]  FULL_LEN = 6'(NUM_NOTES);
   localparam logic [23:0] BEAT     = 24'(BEAT_TICKS);

   // Codes 0 and 7 are not real modes and behave exactly like IDLE.
   function automatic mode_t decode_mode(input logic [2:0] m);
      case (m)
         3'd2:    return M_EDIT;
         3'd3:    return M_DIFF;
         3'd4:    return M_RUN;
         3'd5:    return M_PAUSE;
         3'd6:    return M_FINISH;
         default: return M_IDLE;
      endcase
   endfunction

   logic [2:0]  mode_q;
   mode_t       cur_mode;
   mode_t       prev_mode;
   logic        edit_entry;
   logic        run_reload;
   logic [5:0]  wr_ptr;
   logic        do_write;
   logic [5:0]  song_len;
   logic [1:0]  diff_q;
   logic [23:0] presc;
   logic [23:0] reload_entry;
   logic [23:0] reload_beat;
   logic [3:0]  mem [NUM_NOTES];

   assign cur_mode  = decode_mode(mode);
   assign prev_mode = decode_mode(mode_q);

   // A RUN entry reloads the beat timer unless it is a resume from PAUSE.
   assign edit_entry = (cur_mode == M_EDIT) && (prev_mode != M_EDIT);
   assign run_reload = (cur_mode == M_RUN) && (prev_mode != M_RUN) &&
                       (prev_mode != M_PAUSE);

   // The entry cycle already writes slot 0, so the pointer is forced to 0 there.
   assign wr_ptr   = edit_entry ? 6'd0 : edit_count;
   assign do_write = (cur_mode == M_EDIT) && wr_en && (wr_ptr < FULL_LEN);

   // An empty recording plays the whole memory.
   assign song_len = (edit_count == 6'd0) ? FULL_LEN : edit_count;

   assign reload_entry = (BEAT >> diff) - 24'd1;
   assign reload_beat  = (BEAT >> diff_q) - 24'd1;

   // Previous mode, used to detect mode entry.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) mode_q <= 3'd0;
      else        mode_q <= mode;
   end

   // Note memory and edit pointer; the pointer saturates at a full memory.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         edit_count <= 6'd0;
         for (int i = 0; i < NUM_NOTES; i++) mem[i] <= 4'b0;
      end else if (do_write) begin
         mem[wr_ptr] <= wr_lane;
         edit_count  <= wr_ptr + 6'd1;
      end else if (edit_entry) begin
         edit_count <= 6'd0;
      end
   end

   // Playback: beat prescaler, note stream and song completion per mode.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         presc      <= 24'd0;
         diff_q     <= 2'd0;
         note_count <= 6'd0;
         note_lanes <= 4'b0;
         note_valid <= 1'b0;
         song_done  <= 1'b0;
      end else begin
         note_valid <= 1'b0;
         case (cur_mode)
            M_RUN: begin
               if (run_reload) begin
                  diff_q     <= diff;
                  presc      <= reload_entry;
                  note_count <= 6'd0;
                  note_lanes <= 4'b0;
                  song_done  <= 1'b0;
               end else if (presc != 24'd0) begin
                  presc <= presc - 24'd1;
               end else if (note_count < song_len) begin
                  presc      <= reload_beat;
                  note_lanes <= mem[note_count];
                  note_valid <= 1'b1;
                  note_count <= note_count + 6'd1;
                  song_done  <= (note_count + 6'd1) == song_len;
               end else begin
                  // Song over: the last note is dropped one beat after it
                  // played, then the timer parks at zero.
                  note_lanes <= 4'b0;
               end
            end
            M_PAUSE: begin
               // Everything holds so playback resumes mid-beat.
            end
            M_FINISH: begin
               note_lanes <= 4'b0;
            end
            default: begin
               presc      <= 24'd0;
               note_count <= 6'd0;
               note_lanes <= 4'b0;
               song_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: random and directed mode sequences compared each
// cycle against a timeline model of the song (notes played = RUN edges / P).
module tb_song_sequencer;

   localparam int NN = 42;
   localparam int BT = 16;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       n_rst;
   logic [2:0] mode;
   logic [1:0] diff;
   logic       wr_en;
   logic [3:0] wr_lane;
   logic [5:0] edit_count;
   logic [3:0] note_lanes;
   logic       note_valid;
   logic [5:0] note_count;
   logic       song_done;

   always #5 clk = ~clk;

   song_sequencer #(.NUM_NOTES(NN), .BEAT_TICKS(BT)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .mode       (mode),
      .diff       (diff),
      .wr_en      (wr_en),
      .wr_lane    (wr_lane),
      .edit_count (edit_count),
      .note_lanes (note_lanes),
      .note_valid (note_valid),
      .note_count (note_count),
      .song_done  (song_done)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [3:0] song [NN];
   logic [3:0] exp_q [$];
   int   m_ec, m_len, m_p, m_adv, m_nc, m_prev;
   logic [3:0] m_lanes;
   logic m_valid, m_done;
   int   cyc, entry_edge, last_off, first_off, pulses;

   function automatic int dec(input logic [2:0] m);
      if (m >= 3'd2 && m <= 3'd6) return int'(m);
      return 1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NN; i++) song[i] = 4'b0;
      exp_q.delete();
      m_ec = 0; m_len = NN; m_p = BT; m_adv = 0;
      m_nc = 0; m_lanes = 4'b0; m_valid = 1'b0; m_done = 1'b0;
      m_prev = 1;
   endtask

   task automatic clear_outs();
      m_nc = 0; m_lanes = 4'b0; m_valid = 1'b0; m_done = 1'b0;
   endtask

   // One clock: update the model with the inputs seen at the edge, compare.
   task automatic tick();
      int m, played;
      @(posedge clk);
      cyc++;
      m = dec(mode);
      if (!n_rst) begin
         model_reset();
      end else begin
         case (m)
            2: begin
               if (m_prev != 2) m_ec = 0;
               if (wr_en && m_ec < NN) begin
                  song[m_ec] = wr_lane;
                  m_ec++;
               end
               clear_outs();
            end
            4: begin
               if (m_prev != 4) entry_edge = cyc;
               if (m_prev != 4 && m_prev != 5) begin
                  m_p   = BT >> diff;
                  m_len = (m_ec == 0) ? NN : m_ec;
                  m_adv = 0;
                  clear_outs();
               end else begin
                  m_adv++;
                  played = m_adv / m_p;
                  if (played > m_len) played = m_len;
                  m_nc    = played;
                  m_valid = (m_adv % m_p == 0) && (m_adv / m_p >= 1) && (m_adv / m_p <= m_len);
                  m_done  = (m_adv >= m_len * m_p);
                  m_lanes = (played == 0 || m_adv >= (m_len + 1) * m_p) ? 4'b0 : song[played - 1];
                  if (m_valid) exp_q.push_back(m_lanes);
               end
            end
            5: m_valid = 1'b0;
            6: begin
               m_valid = 1'b0;
               m_lanes = 4'b0;
            end
            default: clear_outs();
         endcase
         m_prev = m;
      end
      #1;
      check_eq("edit_count", edit_count, m_ec);
      check_eq("note_count", note_count, m_nc);
      check_eq("note_lanes", note_lanes, m_lanes);
      check_eq("note_valid", note_valid, m_valid);
      check_eq("song_done",  song_done,  m_done);
      if (note_valid === 1'b1) begin
         pulses++;
         last_off = cyc - entry_edge + 1;
         if (pulses == 1) first_off = last_off;
         if (exp_q.size() != 0) check_eq("pulse_lanes", note_lanes, exp_q.pop_front());
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic record_random(input int n);
      mode = 3'd2;
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_lane = 4'($urandom_range(1, 15));
         tick();
      end
      wr_en = 1'b0;
      tick();
   endtask

   task automatic start_run(input logic [1:0] d);
      mode = 3'd3;
      diff = d;
      tick();
      pulses = 0;
      first_off = 0;
      mode = 3'd4;
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int budget;
      int len, p, pause_left;
      logic [3:0] lanes3 [3];
      lanes3[0] = 4'b0001; lanes3[1] = 4'b0010; lanes3[2] = 4'b0100;
      cyc = 0; entry_edge = 0; last_off = 0; first_off = 0; pulses = 0;
      model_reset();
      n_rst = 1'b0; mode = 3'd1; diff = 2'd0; wr_en = 1'b0; wr_lane = 4'd0;

      // Reset, then idle
      cycles(2);
      #2 n_rst = 1'b1;
      cycles(10);
      check_eq("idle_lanes", note_lanes, 0);
      check_eq("idle_edit", edit_count, 0);

      // Three-note song at difficulty 0
      mode = 3'd2;
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_lane = lanes3[i]; tick();
      end
      wr_en = 1'b0; tick();
      check_eq("edit3", edit_count, 3);
      start_run(2'd0);
      cycles(70);
      check_eq("song3_pulses", pulses, 3);
      check_eq("song3_first", first_off, 17);
      check_eq("song3_last", last_off, 49);
      check_eq("song3_done", song_done, 1);

      // Pause mid-song keeps the remaining beat count
      mode = 3'd1; tick();
      start_run(2'd0);
      cycles(24);
      mode = 3'd5;
      cycles(50);
      check_eq("pause_count", note_count, 1);
      pulses = 0;
      mode = 3'd4;
      cycles(40);
      check_eq("resume_first", first_off, 8);
      check_eq("resume_pulses", pulses, 2);

      // Difficulty 3: P=2; diff changes while running are ignored
      mode = 3'd1; tick();
      start_run(2'd3);
      for (int i = 0; i < 14; i++) begin
         diff = 2'($urandom_range(0, 3));
         tick();
      end
      check_eq("fast_first", first_off, 3);
      check_eq("fast_pulses", pulses, 3);

      // Edit saturation, then full-memory playback
      mode = 3'd1; tick();
      record_random(45);
      check_eq("edit_sat", edit_count, 42);
      start_run(2'd0);
      cycles(42 * 16 + 40);
      check_eq("full_pulses", pulses, 42);
      check_eq("full_done", song_done, 1);
      mode = 3'd2; cycles(2);
      check_eq("edit_reentry", edit_count, 0);
      start_run(2'd3);
      cycles(42 * 2 + 10);
      check_eq("len0_pulses", pulses, 42);

      // FINISH at note_count 2, then IDLE
      mode = 3'd1; tick();
      start_run(2'd1);
      budget = 200;
      while (note_count != 6'd2 && budget > 0) begin
         tick();
         budget--;
      end
      check_eq("reach_two_in_time", budget > 0, 1);
      mode = 3'd6;
      pulses = 0;
      cycles(20);
      check_eq("finish_count", note_count, 2);
      check_eq("finish_lanes", note_lanes, 0);
      check_eq("finish_pulses", pulses, 0);
      mode = 3'd1;
      cycles(2);
      check_eq("after_finish", note_count, 0);

      // Asynchronous reset mid-RUN
      start_run(2'd0);
      cycles(20);
      #3 n_rst = 1'b0;
      #1;
      check_eq("arst_count", note_count, 0);
      check_eq("arst_lanes", note_lanes, 0);
      check_eq("arst_edit", edit_count, 0);
      model_reset();
      mode = 3'd1;
      cycles(2);
      #2 n_rst = 1'b1;
      mode = 3'd2; cycles(2);
      start_run(2'd3);
      cycles(42 * 2 + 10);
      check_eq("cleared_pulses", pulses, 42);

      // Random songs with random pauses, stray writes and invalid idle codes
      for (int it = 0; it < 8; it++) begin
         mode = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
         wr_en = 1'($urandom_range(0, 1));
         tick();
         wr_en = 1'b0;
         len = $urandom_range(1, 8);
         record_random(len);
         diff = 2'($urandom_range(0, 3));
         p = BT >> diff;
         start_run(diff);
         pause_left = 0;
         for (int j = 0; j < (len + 2) * p + 4; j++) begin
            if (pause_left > 0) begin
               mode = 3'd5;
               pause_left--;
            end else begin
               mode = 3'd4;
               if ($urandom_range(0, 9) == 0) pause_left = $urandom_range(1, 6);
            end
            diff    = 2'($urandom_range(0, 3));
            wr_en   = 1'($urandom_range(0, 1));
            wr_lane = 4'($urandom);
            tick();
         end
         wr_en = 1'b0;
         mode = 3'd4;
         cycles((len + 2) * p);
         check_eq("rand_pulses", pulses, len);
         mode = 3'd6;
         cycles(3);
      end

      check_eq("pending_notes", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Consumer side of the game-mode interface: takes the 3-bit `mode` from the mode FSM and drives the note stream.
- EDIT mode: records player-entered notes into an internal note memory.
- RUN mode: plays the recorded notes back on a difficulty-scaled beat, holds position in PAUSE, and reports `note_count` and `song_done` back to the mode FSM.

Parameters:
- NUM_NOTES, 42, song memory depth in notes; range 1..63.
- BEAT_TICKS, 1200000, clk cycles per beat at difficulty 0; 16 <= BEAT_TICKS < 2^24.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- mode  input  3  game mode: 1 IDLE, 2 EDIT, 3 DIFF, 4 RUN, 5 PAUSE, 6 FINISH; 0 and 7 treated as IDLE
- diff  input  2  difficulty select, latched on RUN entry from DIFF
- wr_en  input  1  EDIT-mode note write strobe, one note per asserted cycle
- wr_lane  input  4  lane mask written with wr_en (bit i = lane i)
- edit_count  output  6  number of notes recorded
- note_lanes  output  4  lane mask of the current note
- note_valid  output  1  one-cycle pulse per played note
- note_count  output  6  number of notes played so far
- song_done  output  1  level, last note of the song has been played

Behaviour:
- Reset is n_rst, asynchronous, active-low; clock is clk. Reset clears:
  - all memory entries to 4'b0;
  - edit_count, note_count, note_lanes, note_valid, song_done to 0;
  - the prescaler, latched difficulty, and mode_q.
- mode_q: `mode` registered every cycle. Entry into mode M is the condition `mode==M && mode_q!=M`.
- EDIT:
  - On EDIT entry, edit pointer (edit_count) is cleared to 0 in that cycle; a wr_en in the entry cycle is written to entry 0.
  - wr_en=1 with edit_count<NUM_NOTES: mem[edit_count] <= wr_lane; edit_count++.
  - At edit_count==NUM_NOTES further writes are ignored (saturate, no wrap).
  - wr_en outside EDIT is ignored.
  - note_count, note_lanes, song_done, prescaler are held at 0.
- Song length: len = edit_count, or NUM_NOTES if edit_count==0. edit_count holds its value outside EDIT.
- IDLE / DIFF / invalid mode: note_count=0, note_lanes=0, note_valid=0, song_done=0; prescaler idle.
- RUN entry from DIFF:
  - latch d=diff;
  - P = BEAT_TICKS >> d (P >= 2 guaranteed by the parameter range);
  - prescaler <= P-1; note_count <= 0.
- RUN entry from PAUSE: no reload; the prescaler resumes from its held value.
- RUN entry from any other mode: same as entry from DIFF, using the current diff.
- RUN steady state:
  - Prescaler decrements each cycle; the value visible at entry+k is P-k.
  - Beat occurs in a cycle with prescaler==0 and note_count<len. On a beat:
    - reload P-1;
    - note_lanes <= mem[note_count];
    - note_valid <= 1 for one cycle;
    - note_count++.
  - Registered outputs are visible the cycle after the beat, so the first note_valid appears at entry+P+1 and subsequent ones every P cycles.
- song_done <= 1 when note_count reaches len. After that:
  - no further beats;
  - note_valid stays 0;
  - note_lanes is cleared to 0 one beat period later (prescaler keeps running to time this, then stops).
- PAUSE: prescaler, note_count, note_lanes, and song_done all hold; note_valid=0.
- FINISH:
  - prescaler stops; note_valid=0; note_lanes <= 0;
  - note_count and song_done hold (score display);
  - leaving FINISH to IDLE clears them per the IDLE rules.
- Mode change in the same cycle as a beat: the beat is not taken; the new-mode rules win.
- Mid-operation async reset: everything returns to reset values immediately, including memory contents.

Test Plan:
1. Reset, then idle 10 cycles in IDLE -> all outputs 0, edit_count=0.
2. BEAT_TICKS=16: EDIT, write lanes 0001, 0010, 0100; DIFF with diff=0; RUN at t0 -> edit_count=3; note_valid at t0+17, t0+33, t0+49 with note_lanes 0001, 0010, 0100; note_count 1, 2, 3; song_done=1 from t0+49; no 4th pulse.
3. Pause mid-song: PAUSE at t0+25 for 50 cycles, then RUN -> outputs frozen during PAUSE; next note_valid lands 8 cycles after resume (remaining prescaler count preserved), with no reload.
4. BEAT_TICKS=16, diff=3 -> P=2; pulses every 2 cycles, first at t0+3; diff changes during RUN have no effect.
5. 45 wr_en pulses in EDIT -> edit_count saturates at 42; entries 0..41 are the first 42 values. Re-enter EDIT with zero writes -> edit_count=0, song plays all 42 notes, song_done after the 42nd.
6. FINISH at note_count=2 -> note_lanes=0, note_count holds 2, no note_valid; then IDLE -> note_count=0. Assert n_rst low mid-RUN -> all outputs 0 asynchronously, memory cleared.
